// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 keys and HPS joysticks, applies rotation, registers outputs.
// Optional feature macro AUTOFIRE_EN adds an autofire enable mask and a shared phase counter.
module arcade_input_mapper #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BUTTONS  = 2,
    parameter int COIN_PULSE   = 16,
    parameter int AUTOFIRE_DIV = 200000
) (
    input  logic                               clk_sys,
    input  logic                               RESET,
    input  logic [10:0]                        ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]          joy_in,
    input  logic                               joy_merge,
    input  logic [1:0]                         rotate,
`ifdef AUTOFIRE_EN
    input  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] autofire,
`endif
    output logic [4*NUM_PLAYERS-1:0]           p_dir,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] p_btn,
    output logic [NUM_PLAYERS-1:0]             p_start,
    output logic [NUM_PLAYERS-1:0]             p_coin
);
    localparam int W         = 6 + NUM_BUTTONS;
    localparam int START_BIT = 4 + NUM_BUTTONS;
    localparam int COIN_BIT  = 5 + NUM_BUTTONS;
    localparam int NB_ALL    = NUM_BUTTONS * NUM_PLAYERS;

    logic                          old_tog_q;
    logic [NUM_PLAYERS-1:0][W-1:0] key_q, key_d;
    logic [NUM_PLAYERS-1:0][W-1:0] raw;
    logic [W-1:0]                  joy_or;
    logic [NUM_PLAYERS-1:0]        coin_prev_q, coin_prev_d;
    logic [NUM_PLAYERS-1:0][15:0]  coin_cnt_q, coin_cnt_d;
    logic [4*NUM_PLAYERS-1:0]      p_dir_q, p_dir_d;
    logic [NB_ALL-1:0]             p_btn_q, p_btn_d, btn_req;
    logic [NUM_PLAYERS-1:0]        p_start_q, p_start_d;
    logic [NUM_PLAYERS-1:0]        p_coin_q, p_coin_d;
    logic                          key_event;
    logic                          key_hit;
    int                            key_player;
    int                            key_bit;
    logic                          unused_joy;

    // Only the low W bits of each joystick word carry controls.
    assign unused_joy = ^joy_in;
    assign key_event  = (ps2_key[10] != old_tog_q);

    // Scancode to (player, joystick-layout bit); direction keys accept the extended prefix.
    always_comb begin
        key_hit    = 1'b0;
        key_player = 0;
        key_bit    = 0;
        case (ps2_key[7:0])
            8'h75: begin key_hit = 1'b1; key_bit = 3; end
            8'h72: begin key_hit = 1'b1; key_bit = 2; end
            8'h6B: begin key_hit = 1'b1; key_bit = 1; end
            8'h74: begin key_hit = 1'b1; key_bit = 0; end
            8'h14: begin key_hit = !ps2_key[8]; key_bit = 4; end
            8'h29: begin key_hit = !ps2_key[8] && (NUM_BUTTONS > 1); key_bit = 5; end
            8'h11: begin key_hit = !ps2_key[8] && (NUM_BUTTONS > 2); key_bit = 6; end
            8'h05, 8'h16: begin key_hit = !ps2_key[8]; key_bit = START_BIT; end
            8'h2E: begin key_hit = !ps2_key[8]; key_bit = COIN_BIT; end
            8'h2D: begin key_hit = (NUM_PLAYERS > 1); key_player = 1; key_bit = 3; end
            8'h2B: begin key_hit = (NUM_PLAYERS > 1); key_player = 1; key_bit = 2; end
            8'h23: begin key_hit = (NUM_PLAYERS > 1); key_player = 1; key_bit = 1; end
            8'h34: begin key_hit = (NUM_PLAYERS > 1); key_player = 1; key_bit = 0; end
            8'h1C: begin
                key_hit = !ps2_key[8] && (NUM_PLAYERS > 1);
                key_player = 1; key_bit = 4;
            end
            8'h1B: begin
                key_hit = !ps2_key[8] && (NUM_PLAYERS > 1) && (NUM_BUTTONS > 1);
                key_player = 1; key_bit = 5;
            end
            8'h15: begin
                key_hit = !ps2_key[8] && (NUM_PLAYERS > 1) && (NUM_BUTTONS > 2);
                key_player = 1; key_bit = 6;
            end
            8'h06, 8'h1E: begin
                key_hit = !ps2_key[8] && (NUM_PLAYERS > 1);
                key_player = 1; key_bit = START_BIT;
            end
            8'h36: begin
                key_hit = !ps2_key[8] && (NUM_PLAYERS > 1);
                key_player = 1; key_bit = COIN_BIT;
            end
            default: ;
        endcase
    end

    always_comb begin
        key_d = key_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int b = 0; b < W; b++) begin
                if (key_event && key_hit && key_player == p && key_bit == b)
                    key_d[p][b] = ps2_key[9];
            end
        end
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            joy_or = joy_or | joy_in[16*p +: W];
        for (int p = 0; p < NUM_PLAYERS; p++)
            raw[p] = key_q[p] | (joy_merge ? joy_or : joy_in[16*p +: W]);
    end

    // Raw layout is {U,D,L,R} at bits [3:0]; outputs are {right,left,down,up}.
    always_comb begin
        p_dir_d     = '0;
        btn_req     = '0;
        p_start_d   = '0;
        coin_prev_d = '0;
        coin_cnt_d  = '0;
        p_coin_d    = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            case (rotate)
                2'd0: p_dir_d[4*p +: 4] = {raw[p][0], raw[p][1], raw[p][2], raw[p][3]};
                2'd1: p_dir_d[4*p +: 4] = {raw[p][3], raw[p][2], raw[p][0], raw[p][1]};
                2'd2: p_dir_d[4*p +: 4] = {raw[p][2], raw[p][3], raw[p][1], raw[p][0]};
                default: p_dir_d[4*p +: 4] = {raw[p][1], raw[p][0], raw[p][3], raw[p][2]};
            endcase
            btn_req[NUM_BUTTONS*p +: NUM_BUTTONS] = raw[p][4 +: NUM_BUTTONS];
            p_start_d[p]   = raw[p][START_BIT];
            coin_prev_d[p] = raw[p][COIN_BIT];
            // A running pulse swallows new request edges instead of extending.
            if (coin_cnt_q[p] != 16'd0)
                coin_cnt_d[p] = coin_cnt_q[p] - 16'd1;
            else if (raw[p][COIN_BIT] && !coin_prev_q[p])
                coin_cnt_d[p] = 16'(COIN_PULSE);
            else
                coin_cnt_d[p] = 16'd0;
            p_coin_d[p] = (coin_cnt_d[p] != 16'd0);
        end
    end

`ifdef AUTOFIRE_EN
    localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic [AF_W-1:0] af_cnt_q, af_cnt_d;
    logic            af_phase_q, af_phase_d;

    always_comb begin
        af_cnt_d   = af_cnt_q + 1'b1;
        af_phase_d = af_phase_q;
        if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
        end
        p_btn_d = btn_req & (~autofire | {NB_ALL{af_phase_q}});
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end
`else
    assign p_btn_d = btn_req;
`endif

    // The toggle history tracks ps2_key even in reset so held-over events are discarded.
    always_ff @(posedge clk_sys) begin
        old_tog_q <= ps2_key[10];
        if (RESET) begin
            key_q       <= '0;
            coin_prev_q <= '0;
            coin_cnt_q  <= '0;
            p_dir_q     <= '0;
            p_btn_q     <= '0;
            p_start_q   <= '0;
            p_coin_q    <= '0;
        end else begin
            key_q       <= key_d;
            coin_prev_q <= coin_prev_d;
            coin_cnt_q  <= coin_cnt_d;
            p_dir_q     <= p_dir_d;
            p_btn_q     <= p_btn_d;
            p_start_q   <= p_start_d;
            p_coin_q    <= p_coin_d;
        end
    end

    assign p_dir   = p_dir_q;
    assign p_btn   = p_btn_q;
    assign p_start = p_start_q;
    assign p_coin  = p_coin_q;

endmodule
